ghost_chase_sequencer: RTL
==========================

Name: ghost_chase_sequencer

Overview:
- Initiator-side client of the character coordinate register file. It drives character_type, readwrite, x_in and y_in, and samples x_out and y_out.
- On each move_tick it reads Pacman's position, then reads, moves and writes back each enabled ghost (1..4) in order. Each ghost steps one move toward Pacman.
- It flags ghosts that land on Pacman. It sits between the game-tick generator and the register file, and is the only writer of ghost coordinates.

Parameters:
- STEP, 1, pixels moved per ghost per sweep (1..15)
- MIN_X, 0, lowest legal x pixel
- MAX_X, 159, highest legal x pixel
- MIN_Y, 0, lowest legal y pixel
- MAX_Y, 119, highest legal y pixel

Ports:
- clock_50  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- move_tick  in  1  single-cycle pulse that starts one sweep
- ghost_enable  in  4  bit k-1 enables ghost k; a disabled ghost is skipped (no read, no write)
- rd_x  in  8  register file x_out
- rd_y  in  8  register file y_out
- character_type  out  3  register file character select (0 = Pacman, 1..4 = ghosts)
- readwrite  out  1  register file direction (1 = write)
- x_in  out  8  register file write x
- y_in  out  8  register file write y
- busy  out  1  high from the cycle after the accepted tick until DONE inclusive
- sweep_done  out  1  one-cycle pulse in DONE
- caught  out  1  one-cycle pulse in DONE if any ghost ended the sweep on Pacman
- caught_mask  out  4  per-ghost caught flags; updated in DONE and held until the next DONE

Behaviour:
- All outputs are registered.
- Reset values: character_type = 0, readwrite = 0, x_in = 0, y_in = 0, busy = 0, sweep_done = 0, caught = 0, caught_mask = 0, state = IDLE.
- Reset asserted mid-sweep: the sweep is abandoned. readwrite drops to 0 immediately; there is no partial write and no done pulse.
- Read timing: the register file captures on the edge ending the cycle in which character_type is driven with readwrite = 0. rd_x/rd_y are therefore sampled one cycle later.
- States:
  - IDLE: readwrite = 0. move_tick -> RD_PAC.
  - RD_PAC: drive type 0, readwrite 0 -> WT_PAC.
  - WT_PAC: latch px = rd_x, py = rd_y; k = lowest enabled ghost -> RD_G, or DONE if none.
  - RD_G: drive type k, readwrite 0 -> WT_G.
  - WT_G: latch gx, gy -> CALC.
  - CALC: compute nx, ny -> WR_G.
  - WR_G: drive type k, readwrite 1, x_in = nx, y_in = ny for exactly one cycle; set caught bit k-1 if (nx, ny) == (px, py). Then k = next enabled ghost -> RD_G, or DONE.
  - DONE: sweep_done = 1; caught = OR of the sweep's caught bits; caught_mask = sweep bits -> IDLE.
- readwrite is 1 only in WR_G.
- Latency:
  - 2 + 5 cycles per enabled ghost (RD_G, WT_G, CALC, WR_G plus 1) + DONE.
  - All 4 ghosts enabled: busy for 23 cycles; sweep_done occurs 23 cycles after the tick edge.
- move_tick while busy is ignored and not queued.
- Movement arithmetic uses 9-bit signed values: dx = px - gx, dy = py - gy.
  - |dx| >= |dy| and dx != 0: move on the x axis by sign(dx) * min(STEP, |dx|); y unchanged.
  - Otherwise, if dy != 0: move on the y axis the same way; x unchanged.
  - dx = dy = 0: no move; the write still occurs and the caught bit is set.
  - A tie (|dx| == |dy|) picks the x axis.
  - Movement never overshoots Pacman.
  - The result is clamped to [MIN_X, MAX_X] and [MIN_Y, MAX_Y]. It never wraps at 0 or 255.
- Pacman is sampled once per sweep. Changes to Pacman's position during a sweep take effect on the next sweep.

Test Plan:
- Reset defaults plus Pacman (60,35), STEP = 1, all enabled, one tick: writes are g1 -> (41,35), g2 -> (46,35), g3 -> (51,35), g4 -> (56,35) in type order. Each readwrite pulse is one cycle. sweep_done comes 23 cycles after the tick; caught = 0.
- Pacman (45,40), ghost2 at (45,35), only ghost 2 enabled: the only write is type 2 -> (45,36); busy is 8 cycles.
- STEP = 4, Pacman (43,35), ghost1 at (40,35), only ghost 1 enabled: write (43,35), caught = 1, caught_mask = 0001.
- Tie case, Pacman (50,50), ghost1 at (40,40): the ghost moves on x to (41,40). With MIN_X = 0, Pacman (0,0) and ghost at (0,5): the ghost moves to (0,4) with no x underflow.
- A second move_tick mid-sweep is ignored, giving exactly 4 writes. ghost_enable = 0000 gives no writes and sweep_done 3 cycles after the tick.
- reset_n asserted during WR_G of ghost 2: readwrite drops to 0 asynchronously, busy = 0, and no sweep_done. Releasing reset and ticking restarts from RD_PAC.

Source files
------------

// File: rtl/ghost_chase_sequencer.sv
// Ghost movement sequencer: once per move_tick it reads Pacman, then reads, steps and
// writes back each enabled ghost through the character coordinate register file.
//
// state  | meaning
// IDLE   | waiting for move_tick
// RD_PAC | address Pacman (type 0) for read
// WT_PAC | latch Pacman position, pick first enabled ghost
// RD_G   | address ghost k for read
// WT_G   | latch ghost position
// CALC   | compute stepped position
// WR_G   | one-cycle write of ghost k, record catch
// ADV    | select next enabled ghost
// DONE   | pulse sweep_done / caught, publish caught_mask
module ghost_chase_sequencer #(
  parameter int STEP  = 1,
  parameter int MIN_X = 0,
  parameter int MAX_X = 159,
  parameter int MIN_Y = 0,
  parameter int MAX_Y = 119
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       move_tick,
  input  logic [3:0] ghost_enable,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic [2:0] character_type,
  output logic       readwrite,
  output logic [7:0] x_in,
  output logic [7:0] y_in,
  output logic       busy,
  output logic       sweep_done,
  output logic       caught,
  output logic [3:0] caught_mask
);

  typedef enum logic [3:0] {
    IDLE, RD_PAC, WT_PAC, RD_G, WT_G, CALC, WR_G, ADV, DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  k, k_nx;
  logic [2:0]  type_nx;
  logic        rw_nx, busy_nx, done_nx;
  logic [7:0]  px, py, gx, gy;
  logic [3:0]  hit_mask;
  logic [1:0]  gidx;

  logic signed [8:0] dx, dy;
  logic [8:0]        adx, ady, sx, sy;
  int                nx_i, ny_i;
  logic [7:0]        nx, ny;

  // lowest enabled ghost with index above cur; 0 when none remain
  function automatic logic [2:0] next_ghost(input logic [3:0] en, input logic [2:0] cur);
    next_ghost = 3'd0;
    for (int i = 4; i >= 1; i--) begin
      if (en[2'(i - 1)] && (i > int'(cur))) next_ghost = 3'(i);
    end
  endfunction

  always_comb begin
    state_nx = state;
    k_nx     = k;
    case (state)
      IDLE:    if (move_tick) state_nx = RD_PAC;
      RD_PAC:  state_nx = WT_PAC;
      WT_PAC: begin
        k_nx     = next_ghost(ghost_enable, 3'd0);
        state_nx = (k_nx == 3'd0) ? DONE : RD_G;
      end
      RD_G:    state_nx = WT_G;
      WT_G:    state_nx = CALC;
      CALC:    state_nx = WR_G;
      WR_G:    state_nx = ADV;
      ADV: begin
        k_nx     = next_ghost(ghost_enable, k);
        state_nx = (k_nx == 3'd0) ? DONE : RD_G;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    type_nx = 3'd0;
    if (state_nx == RD_G || state_nx == WT_G || state_nx == CALC || state_nx == WR_G)
      type_nx = k_nx;
    rw_nx   = (state_nx == WR_G);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  // move one step along the dominant axis (x wins ties), never past Pacman
  always_comb begin
    dx   = $signed({1'b0, px}) - $signed({1'b0, gx});
    dy   = $signed({1'b0, py}) - $signed({1'b0, gy});
    adx  = dx[8] ? 9'(-dx) : 9'(dx);
    ady  = dy[8] ? 9'(-dy) : 9'(dy);
    sx   = (adx < 9'(STEP)) ? adx : 9'(STEP);
    sy   = (ady < 9'(STEP)) ? ady : 9'(STEP);
    nx_i = int'(gx);
    ny_i = int'(gy);
    if (adx >= ady && dx != 9'sd0)
      nx_i = dx[8] ? nx_i - int'(sx) : nx_i + int'(sx);
    else if (dy != 9'sd0)
      ny_i = dy[8] ? ny_i - int'(sy) : ny_i + int'(sy);
    if (nx_i < MIN_X) nx_i = MIN_X;
    else if (nx_i > MAX_X) nx_i = MAX_X;
    if (ny_i < MIN_Y) ny_i = MIN_Y;
    else if (ny_i > MAX_Y) ny_i = MAX_Y;
    nx   = 8'(nx_i);
    ny   = 8'(ny_i);
    gidx = 2'(k - 3'd1);
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      k              <= 3'd0;
      character_type <= 3'd0;
      readwrite      <= 1'b0;
      busy           <= 1'b0;
      sweep_done     <= 1'b0;
      caught         <= 1'b0;
      caught_mask    <= 4'd0;
    end else begin
      state          <= state_nx;
      k              <= k_nx;
      character_type <= type_nx;
      readwrite      <= rw_nx;
      busy           <= busy_nx;
      sweep_done     <= done_nx;
      caught         <= done_nx && (|hit_mask);
      if (done_nx) caught_mask <= hit_mask;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      px       <= 8'd0;
      py       <= 8'd0;
      gx       <= 8'd0;
      gy       <= 8'd0;
      x_in     <= 8'd0;
      y_in     <= 8'd0;
      hit_mask <= 4'd0;
    end else begin
      case (state)
        RD_PAC: hit_mask <= 4'd0;
        WT_PAC: begin
          px <= rd_x;
          py <= rd_y;
        end
        WT_G: begin
          gx <= rd_x;
          gy <= rd_y;
        end
        CALC: begin
          x_in <= nx;
          y_in <= ny;
        end
        WR_G: if (x_in == px && y_in == py) hit_mask[gidx] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
